// File: rtl/calc2_req_driver_if.sv
// Transaction, DUT-port and completion signals of one calc2 request driver.
interface calc2_req_driver_if;
   logic        txn_valid;
   logic        txn_ready;
   logic [3:0]  txn_cmd;
   logic [31:0] txn_op1;
   logic [31:0] txn_op2;
   logic [1:0]  txn_tag;
   logic [3:0]  req_cmd_out;
   logic [31:0] req_data_out;
   logic [1:0]  req_tag_out;
   logic [1:0]  dut_resp_in;
   logic [31:0] dut_data_in;
   logic [1:0]  dut_tag_in;
   logic        rsp_valid;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_tag;
   logic        rsp_timeout;
   logic        spurious;
   logic [3:0]  busy_tags;

   // Traffic source / completion monitor side.
   modport master (
      output txn_valid, txn_cmd, txn_op1, txn_op2, txn_tag,
      output dut_resp_in, dut_data_in, dut_tag_in,
      input  txn_ready, req_cmd_out, req_data_out, req_tag_out,
      input  rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout,
      input  spurious, busy_tags
   );

   // Request driver side.
   modport slave (
      input  txn_valid, txn_cmd, txn_op1, txn_op2, txn_tag,
      input  dut_resp_in, dut_data_in, dut_tag_in,
      output txn_ready, req_cmd_out, req_data_out, req_tag_out,
      output rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_timeout,
      output spurious, busy_tags
   );
endinterface

// File: rtl/calc2_req_driver.sv
// Per-port calc2 request driver: splits a transaction into the two-cycle
// request sequence, tracks four tags and reports completions or timeouts.
module calc2_req_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5
) (
   input  logic              c_clk,
   input  logic              reset,
   calc2_req_driver_if.slave bus
);
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 2;
   localparam int unsigned RESP_W = 2;
   localparam int unsigned NTAGS  = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP1  = 2'd1,
      OP2  = 2'd2
   } state_t;

   state_t state, state_d;

   logic              ready_c;
   logic              accept;
   logic [CMD_W-1:0]  cmd_q;
   logic [DATA_W-1:0] op2_q;
   logic [TAG_W-1:0]  tag_q;

   logic [CMD_W-1:0]  req_cmd_q,  req_cmd_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic [TAG_W-1:0]  req_tag_q,  req_tag_d;

   logic [NTAGS-1:0]            busy_q, busy_d;
   logic [NTAGS-1:0]            exp_q, exp_d;
   logic [NTAGS-1:0]            cand;
   logic [NTAGS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   logic              hit, match;
   logic              to_valid;
   logic [TAG_W-1:0]  to_idx;

   logic              rsp_valid_q,   rsp_valid_d;
   logic [RESP_W-1:0] rsp_resp_q,    rsp_resp_d;
   logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
   logic [TAG_W-1:0]  rsp_tag_q,     rsp_tag_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              spurious_q,    spurious_d;

   // Ready only when idle and the offered tag is free; held low during reset.
   assign ready_c       = ~reset & (state == IDLE) & ~busy_q[bus.txn_tag];
   assign accept        = bus.txn_valid & ready_c;
   assign bus.txn_ready = ready_c;

   // Request sequencing: IDLE -> OP1 -> OP2 -> IDLE, req outputs computed one cycle ahead.
   always_comb begin
      state_d    = state;
      req_cmd_d  = '0;
      req_data_d = '0;
      req_tag_d  = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_d    = OP1;
               req_cmd_d  = bus.txn_cmd;
               req_data_d = bus.txn_op1;
               req_tag_d  = bus.txn_tag;
            end
         end
         OP1: begin
            state_d    = OP2;
            req_cmd_d  = cmd_q;
            req_data_d = op2_q;
            req_tag_d  = tag_q;
         end
         OP2:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Request output registers and the latched second beat.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         req_cmd_q  <= '0;
         req_data_q <= '0;
         req_tag_q  <= '0;
         cmd_q      <= '0;
         op2_q      <= '0;
         tag_q      <= '0;
      end else begin
         req_cmd_q  <= req_cmd_d;
         req_data_q <= req_data_d;
         req_tag_q  <= req_tag_d;
         if (accept) begin
            cmd_q <= bus.txn_cmd;
            op2_q <= bus.txn_op2;
            tag_q <= bus.txn_tag;
         end
      end
   end

   // Tag tracking and completion arbitration: matched response first, then lowest expired tag.
   always_comb begin
      hit           = (bus.dut_resp_in != '0);
      match         = hit & busy_q[bus.dut_tag_in];
      spurious_d    = hit & ~busy_q[bus.dut_tag_in];
      busy_d        = busy_q;
      cnt_d         = cnt_q;
      cand          = '0;
      to_valid      = 1'b0;
      to_idx        = '0;
      rsp_valid_d   = 1'b0;
      rsp_resp_d    = '0;
      rsp_data_d    = '0;
      rsp_tag_d     = '0;
      rsp_timeout_d = 1'b0;
      for (int i = 0; i < int'(NTAGS); i++) begin
         if (busy_q[i] && (cnt_q[i] != LIMIT)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
         cand[i] = busy_q[i] & (exp_q[i] | (cnt_q[i] == LIMIT))
                   & ~(match & (bus.dut_tag_in == TAG_W'(i)));
      end
      for (int i = int'(NTAGS) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            to_valid = 1'b1;
            to_idx   = TAG_W'(i);
         end
      end
      exp_d = cand;
      if (match) begin
         rsp_valid_d = 1'b1;
         rsp_resp_d  = bus.dut_resp_in;
         rsp_data_d  = bus.dut_data_in;
         rsp_tag_d   = bus.dut_tag_in;
         busy_d[bus.dut_tag_in] = 1'b0;
         cnt_d[bus.dut_tag_in]  = '0;
      end else if (to_valid) begin
         rsp_valid_d   = 1'b1;
         rsp_timeout_d = 1'b1;
         rsp_tag_d     = to_idx;
         busy_d[to_idx] = 1'b0;
         exp_d[to_idx]  = 1'b0;
         cnt_d[to_idx]  = '0;
      end
      if (accept) begin
         busy_d[bus.txn_tag] = 1'b1;
         exp_d[bus.txn_tag]  = 1'b0;
         cnt_d[bus.txn_tag]  = '0;
      end
   end

   // Tag state and completion output registers.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         busy_q        <= '0;
         exp_q         <= '0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_resp_q    <= '0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
         spurious_q    <= 1'b0;
      end else begin
         busy_q        <= busy_d;
         exp_q         <= exp_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_data_q    <= rsp_data_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_timeout_q <= rsp_timeout_d;
         spurious_q    <= spurious_d;
      end
   end

   assign bus.req_cmd_out  = req_cmd_q;
   assign bus.req_data_out = req_data_q;
   assign bus.req_tag_out  = req_tag_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_resp     = rsp_resp_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_tag      = rsp_tag_q;
   assign bus.rsp_timeout  = rsp_timeout_q;
   assign bus.spurious     = spurious_q;
   assign bus.busy_tags    = busy_q;
endmodule

// File: tb/tb_calc2_req_driver.sv
// Self-checking bench for calc2_req_driver: directed scenarios plus random
// traffic, compared against a deadline-based transaction model.
module tb_calc2_req_driver;
   localparam int TMO = 16;

   logic c_clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   calc2_req_driver_if bus();

   calc2_req_driver #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 c_clk = ~c_clk;

   // Model: absolute edge numbers, last accept edge, outstanding set with deadlines.
   int          edge_n;
   int          acc_edge;
   logic [3:0]  m_cmd;
   logic [31:0] m_op2;
   logic [1:0]  m_tag;
   bit          outst [4];
   int          deadline [4];
   logic [37:0] e_req;
   logic [37:0] e_rsp;
   logic        e_spur;
   logic [3:0]  e_busy;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [37:0] req_now();
      return {bus.req_cmd_out, bus.req_data_out, bus.req_tag_out};
   endfunction

   function automatic logic [37:0] rsp_now();
      return {bus.rsp_valid, bus.rsp_resp, bus.rsp_data, bus.rsp_tag, bus.rsp_timeout};
   endfunction

   function automatic logic model_ready(input logic [1:0] t);
      return (edge_n >= acc_edge + 3) && !outst[t];
   endfunction

   task automatic model_reset();
      edge_n   = 0;
      acc_edge = -100;
      for (int t = 0; t < 4; t++) begin
         outst[t]    = 1'b0;
         deadline[t] = 0;
      end
      e_req  = '0;
      e_rsp  = '0;
      e_spur = 1'b0;
      e_busy = '0;
   endtask

   // One clock: drive at negedge, check ready, advance model, check registered outputs.
   task automatic step(input logic v, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [1:0] tg, input logic [1:0] resp,
                       input logic [31:0] rdata, input logic [1:0] rtag);
      logic rdy;
      bit   matched;
      bit   found;
      bus.txn_valid   = v;
      bus.txn_cmd     = cmd;
      bus.txn_op1     = op1;
      bus.txn_op2     = op2;
      bus.txn_tag     = tg;
      bus.dut_resp_in = resp;
      bus.dut_data_in = rdata;
      bus.dut_tag_in  = rtag;
      #1;
      rdy = model_ready(tg);
      check("txn_ready", 64'(bus.txn_ready), 64'(rdy));
      matched = 1'b0;
      found   = 1'b0;
      e_spur  = 1'b0;
      e_rsp   = '0;
      if (v && rdy)                    e_req = {cmd, op1, tg};
      else if (edge_n == acc_edge + 1) e_req = {m_cmd, m_op2, m_tag};
      else                             e_req = '0;
      if (resp != 2'd0) begin
         if (outst[rtag]) begin
            e_rsp       = {1'b1, resp, rdata, rtag, 1'b0};
            outst[rtag] = 1'b0;
            matched     = 1'b1;
         end else begin
            e_spur = 1'b1;
         end
      end
      if (!matched) begin
         for (int t = 0; t < 4; t++) begin
            if (!found && outst[t] && edge_n >= deadline[t]) begin
               e_rsp    = {1'b1, 2'b00, 32'h0, 2'(t), 1'b1};
               outst[t] = 1'b0;
               found    = 1'b1;
            end
         end
      end
      if (v && rdy) begin
         acc_edge     = edge_n;
         m_cmd        = cmd;
         m_op2        = op2;
         m_tag        = tg;
         outst[tg]    = 1'b1;
         deadline[tg] = edge_n + TMO + 1;
      end
      for (int t = 0; t < 4; t++) e_busy[t] = outst[t];
      edge_n++;
      @(posedge c_clk);
      @(negedge c_clk);
      check("req",      64'(req_now()),      64'(e_req));
      check("rsp",      64'(rsp_now()),      64'(e_rsp));
      check("spurious", 64'(bus.spurious),   64'(e_spur));
      check("busy",     64'(bus.busy_tags),  64'(e_busy));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 2'd0);
   endtask

   task automatic accept_tag(input logic [1:0] tg);
      step(1'b1, 4'd5, 32'h100 + 32'(tg), 32'h200 + 32'(tg), tg, 2'd0, 32'd0, 2'd0);
   endtask

   task automatic respond(input logic [1:0] resp, input logic [31:0] rdata, input logic [1:0] rtag);
      step(1'b0, 4'd0, 32'd0, 32'd0, 2'd0, resp, rdata, rtag);
   endtask

   initial begin
      logic [1:0]  r_resp;
      reset           = 1'b0;
      bus.txn_valid   = 1'b0;
      bus.txn_cmd     = '0;
      bus.txn_op1     = '0;
      bus.txn_op2     = '0;
      bus.txn_tag     = '0;
      bus.dut_resp_in = '0;
      bus.dut_data_in = '0;
      bus.dut_tag_in  = '0;
      #2 reset = 1'b1;
      #1;
      check("rst_req",  64'(req_now()), 64'd0);
      check("rst_rsp",  64'(rsp_now()), 64'd0);
      check("rst_misc", 64'({bus.txn_ready, bus.spurious, bus.busy_tags}), 64'd0);
      @(negedge c_clk);
      @(negedge c_clk);
      reset = 1'b0;
      model_reset();

      // Add with a busy-tag offer and a second tag accepted after the gap cycle.
      step(1'b1, 4'd1, 32'h10, 32'h0B, 2'd2, 2'd0, 32'd0, 2'd0);
      check("add_op1", 64'(req_now()), 64'({4'd1, 32'h10, 2'd2}));
      check("add_busy", 64'(bus.busy_tags), 64'b0100);
      step(1'b1, 4'd1, 32'h99, 32'h99, 2'd2, 2'd0, 32'd0, 2'd0);
      check("add_op2", 64'(req_now()), 64'({4'd1, 32'h0B, 2'd2}));
      step(1'b1, 4'd2, 32'h5, 32'h9, 2'd3, 2'd0, 32'd0, 2'd0);
      check("add_gap", 64'(req_now()), 64'd0);
      step(1'b1, 4'd2, 32'h5, 32'h9, 2'd3, 2'd0, 32'd0, 2'd0);
      check("tag3_acc", 64'(bus.busy_tags), 64'b1100);
      idle(1);
      respond(2'd1, 32'h1B, 2'd2);
      check("add_rsp", 64'(rsp_now()), 64'({1'b1, 2'd1, 32'h1B, 2'd2, 1'b0}));
      respond(2'd2, 32'hFFFF_FFFC, 2'd3);
      check("err_rsp", 64'(rsp_now()), 64'({1'b1, 2'd2, 32'hFFFF_FFFC, 2'd3, 1'b0}));
      check("err_busy", 64'(bus.busy_tags), 64'd0);

      // Timeout after TMO+1 edges, then a late response is spurious.
      accept_tag(2'd1);
      idle(TMO);
      check("tmo_early", 64'(bus.rsp_valid), 64'd0);
      idle(1);
      check("tmo_rsp", 64'(rsp_now()), 64'({1'b1, 2'd0, 32'd0, 2'd1, 1'b1}));
      respond(2'd1, 32'h55, 2'd1);
      check("late_spur", 64'({bus.spurious, bus.rsp_valid}), 64'b10);

      // Response on the same edge the counter is at its limit wins.
      accept_tag(2'd0);
      idle(TMO);
      respond(2'd1, 32'h77, 2'd0);
      check("lim_rsp", 64'(rsp_now()), 64'({1'b1, 2'd1, 32'h77, 2'd0, 1'b0}));
      idle(1);
      check("lim_quiet", 64'(bus.rsp_valid), 64'd0);
      idle(2);

      // Collision: responses hold off expired tags, then 0 and 3 drain lowest first.
      accept_tag(2'd3);
      idle(2);
      accept_tag(2'd0);
      idle(2);
      accept_tag(2'd2);
      idle(2);
      accept_tag(2'd1);
      idle(7);
      respond(2'd1, 32'hA1, 2'd1);
      check("col_r1", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_timeout}), 64'({1'b1, 2'd1, 1'b0}));
      step(1'b1, 4'd6, 32'h3, 32'h4, 2'd1, 2'd1, 32'hA2, 2'd2);
      check("col_r2", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_timeout}), 64'({1'b1, 2'd2, 1'b0}));
      respond(2'd3, 32'hA3, 2'd1);
      check("col_r3", 64'({bus.rsp_valid, bus.rsp_tag, bus.rsp_timeout}), 64'({1'b1, 2'd1, 1'b0}));
      idle(1);
      check("col_t0", 64'(rsp_now()), 64'({1'b1, 2'd0, 32'd0, 2'd0, 1'b1}));
      idle(1);
      check("col_t3", 64'(rsp_now()), 64'({1'b1, 2'd0, 32'd0, 2'd3, 1'b1}));
      check("col_busy", 64'(bus.busy_tags), 64'd0);

      // Asynchronous reset during OP2.
      accept_tag(2'd2);
      idle(1);
      reset = 1'b1;
      #1;
      check("rst2_req",  64'(req_now()), 64'd0);
      check("rst2_rsp",  64'(rsp_now()), 64'd0);
      check("rst2_misc", 64'({bus.txn_ready, bus.spurious, bus.busy_tags}), 64'd0);
      @(negedge c_clk);
      reset           = 1'b0;
      bus.txn_valid   = 1'b0;
      bus.txn_tag     = 2'd2;
      bus.dut_resp_in = 2'd0;
      model_reset();
      #1;
      check("rst2_ready", 64'(bus.txn_ready), 64'd1);
      check("rst2_busy",  64'(bus.busy_tags), 64'd0);
      idle(2);

      // Random traffic against the model.
      for (int k = 0; k < 2500; k++) begin
         r_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         step(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom), 32'($urandom),
              2'($urandom_range(0, 3)), r_resp, 32'($urandom), 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
